// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the rest of the system:
// lock/warm-reset requests in, sequenced resets and status out.
interface reset_sequencer_if #(
  parameter int CNT_W = 9
);
  logic             lock;
  logic             sw_req;
  logic             rst1_n;
  logic             rst2;
  logic             ready;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

  // System side: drives lock and warm-reset requests, observes the resets.
  modport master (
    output lock, sw_req,
    input  rst1_n, rst2, ready, state, cnt
  );

  // Sequencer side.
  modport slave (
    input  lock, sw_req,
    output rst1_n, rst2, ready, state, cnt
  );
endinterface

// File: rtl/reset_sequencer.sv
// Two-domain reset sequencer. Resets assert asynchronously from the board
// reset, deassert synchronously in their own domain, and are released in
// order: clock1 after a lock-qualified hold, then clock2 via a handshake.
module reset_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int SW_PULSE    = 8,
  parameter int CNT_W       = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock1,
  input  logic              reset,
  input  logic              clock2,
  reset_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    RST       = 3'd0,
    WAIT_LOCK = 3'd1,
    HOLD      = 3'd2,
    REL2      = 3'd3,
    RUN       = 3'd4,
    SW_RST    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_PULSE - 1);

  // Counter step that sticks at its limit instead of running past it.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

  logic [SYNC_STAGES-1:0] rst_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [SYNC_STAGES-1:0] rel_sync;
  logic                   rst_s;
  logic                   lock_s;
  logic                   ack_s;
  logic                   rel2_s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst1_n_q, rst1_n_d;
  logic             rel_req_q, rel_req_d;
  logic             ready_q, ready_d;
  logic             rst2_q;

  // Local release of the board reset into clock1.
  always_ff @(posedge clock1 or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_s = rst_sync[SYNC_STAGES-1];

  // Lock synchronizer; it only starts sampling once the local reset has been
  // released, so lock latency is always measured from that point.
  always_ff @(posedge clock1 or negedge reset) begin
    if (!reset)      lock_sync <= '0;
    else if (!rst_s) lock_sync <= '0;
    else             lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.lock};
  end
  assign lock_s = lock_sync[SYNC_STAGES-1];

  // Return path of the clock2 release status back into clock1.
  always_ff @(posedge clock1 or negedge reset) begin
    if (!reset) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], rel2_s};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Forward path of the release request into clock2.
  always_ff @(posedge clock2 or negedge reset) begin
    if (!reset) rel_sync <= '0;
    else        rel_sync <= {rel_sync[SYNC_STAGES-2:0], rel_req_q};
  end
  assign rel2_s = rel_sync[SYNC_STAGES-1];

  // clock2 reset: set asynchronously, cleared only by the synchronized release.
  always_ff @(posedge clock2 or negedge reset) begin
    if (!reset) rst2_q <= 1'b1;
    else        rst2_q <= ~rel2_s;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clock1 or negedge reset) begin
    if (!reset) begin
      state_q   <= RST;
      cnt_q     <= '0;
      rst1_n_q  <= 1'b0;
      rel_req_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst1_n_q  <= rst1_n_d;
      rel_req_q <= rel_req_d;
      ready_q   <= ready_d;
    end
  end

  // Next state and next register values; lock loss has priority everywhere.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst1_n_d  = rst1_n_q;
    rel_req_d = rel_req_q;
    case (state_q)
      RST: begin
        cnt_d     = '0;
        rst1_n_d  = 1'b0;
        rel_req_d = 1'b0;
        if (rst_s) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cnt_d     = '0;
        rst1_n_d  = 1'b0;
        rel_req_d = 1'b0;
        if (lock_s) state_d = HOLD;
      end
      HOLD: begin
        rst1_n_d  = 1'b0;
        rel_req_d = 1'b0;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = REL2;
          rst1_n_d  = 1'b1;
          rel_req_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      REL2: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          rst1_n_d  = 1'b0;
          rel_req_d = 1'b0;
        end else if (ack_s) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          rst1_n_d  = 1'b0;
          rel_req_d = 1'b0;
        end else if (bus.sw_req) begin
          state_d   = SW_RST;
          cnt_d     = '0;
          rst1_n_d  = 1'b0;
          rel_req_d = 1'b0;
        end
      end
      SW_RST: begin
        rst1_n_d  = 1'b0;
        rel_req_d = 1'b0;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == SW_LAST && !ack_s) begin
          // clock2 has been seen back in reset and the minimum pulse is done
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q, SW_LAST);
        end
      end
      default: begin
        state_d   = RST;
        cnt_d     = '0;
        rst1_n_d  = 1'b0;
        rel_req_d = 1'b0;
      end
    endcase
    ready_d = (state_d == RUN);
  end

  assign bus.rst1_n = rst1_n_q;
  assign bus.rst2   = rst2_q;
  assign bus.ready  = ready_q;
  assign bus.state  = state_q;
  assign bus.cnt    = cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed-plus-random bench for reset_sequencer. Expected timing comes from
// the sequencing rules: edge counts from reset release, hold length, warm
// reset pulse length and synchronizer depth.
module tb_reset_sequencer;
  localparam int HOLD_CYCLES = 16;
  localparam int SW_PULSE    = 8;
  localparam int CNT_W       = 9;
  localparam int SYNC_STAGES = 2;
  localparam int P1          = 10;
  localparam int P2          = 14;

  localparam int S_RST = 0, S_WAIT = 1, S_HOLD = 2, S_REL2 = 3, S_RUN = 4, S_SW = 5;

  // clock1 edges after release at which each phase is first observed
  localparam int E_WAIT = SYNC_STAGES + 1;
  localparam int E_HOLD = E_WAIT + SYNC_STAGES;

  logic clock1 = 1'b0;
  logic clock2 = 1'b0;
  logic reset;
  bit   clk2_en = 1'b1;
  int   c2_edges = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  reset_sequencer_if #(.CNT_W(CNT_W)) bus();

  reset_sequencer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .SW_PULSE(SW_PULSE),
    .CNT_W(CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clock1(clock1),
    .reset(reset),
    .clock2(clock2),
    .bus(bus)
  );

  always #(P1/2) clock1 = ~clock1;
  always #(P2/2) if (clk2_en) clock2 = ~clock2;
  always @(posedge clock2) c2_edges <= c2_edges + 1;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input int exp);
    n_checks++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock1);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chkn({tag, "_state"}, 32'(bus.state), S_RST);
    chkn({tag, "_cnt"}, 32'(bus.cnt), 0);
    chk1({tag, "_rst1_n"}, bus.rst1_n, 1'b0);
    chk1({tag, "_rst2"}, bus.rst2, 1'b1);
    chk1({tag, "_ready"}, bus.ready, 1'b0);
  endtask

  // Release reset and follow RST -> WAIT_LOCK -> HOLD entry.
  task automatic release_to_hold(input bit poke);
    int es;
    @(negedge clock1);
    reset = 1'b1;
    for (int e = 1; e <= E_HOLD; e++) begin
      bus.sw_req = poke && (e == E_WAIT + 1);
      tick();
      bus.sw_req = 1'b0;
      es = (e < E_WAIT) ? S_RST : ((e < E_HOLD) ? S_WAIT : S_HOLD);
      chkn("rel_state", 32'(bus.state), es);
      chkn("rel_cnt", 32'(bus.cnt), 0);
      chk1("rel_rst1_n", bus.rst1_n, 1'b0);
      chk1("rel_rst2", bus.rst2, 1'b1);
    end
  endtask

  // Starting right after HOLD entry: HOLD_CYCLES edges of counting, then REL2.
  task automatic hold_walk(input bit poke, input int poke_at);
    for (int k = 1; k <= HOLD_CYCLES; k++) begin
      bus.sw_req = poke && (k == poke_at);
      tick();
      bus.sw_req = 1'b0;
      if (k < HOLD_CYCLES) begin
        chkn("hold_state", 32'(bus.state), S_HOLD);
        chkn("hold_cnt", 32'(bus.cnt), k);
        chk1("hold_rst1_n", bus.rst1_n, 1'b0);
      end else begin
        chkn("rel2_state", 32'(bus.state), S_REL2);
        chk1("rel2_rst1_n", bus.rst1_n, 1'b1);
      end
      chk1("hold_rst2", bus.rst2, 1'b1);
    end
  endtask

  // In REL2: wait (bounded) for the clock2 handshake to bring us to RUN.
  task automatic wait_ready(input bit poke);
    bit seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bus.sw_req = poke && (k == 0);
      tick();
      bus.sw_req = 1'b0;
      if (bus.ready) begin
        seen = 1'b1;
        break;
      end
      chkn("rel2_wait_state", 32'(bus.state), S_REL2);
    end
    chk1("ready_up", seen, 1'b1);
    chkn("run_state", 32'(bus.state), S_RUN);
    chk1("run_rst1_n", bus.rst1_n, 1'b1);
    chk1("run_rst2", bus.rst2, 1'b0);
  endtask

  task automatic power_up(input bit poke);
    release_to_hold(poke);
    hold_walk(poke, int'($urandom_range(1, HOLD_CYCLES)));
    wait_ready(poke);
  endtask

  // Warm reset from RUN and full recovery.
  task automatic sw_test();
    int c0;
    bit r2_ok = 1'b0;
    bit done  = 1'b0;
    bus.sw_req = 1'b1;
    tick();
    bus.sw_req = 1'b0;
    chkn("sw_state", 32'(bus.state), S_SW);
    chk1("sw_rst1_n", bus.rst1_n, 1'b0);
    chk1("sw_ready", bus.ready, 1'b0);
    chkn("sw_cnt0", 32'(bus.cnt), 0);
    c0 = c2_edges;
    for (int k = 1; k <= 60 && !done; k++) begin
      tick();
      if (!r2_ok && (c2_edges - c0) >= 3) begin
        chk1("sw_rst2", bus.rst2, 1'b1);
        r2_ok = 1'b1;
      end
      if (bus.state == 3'(S_SW)) begin
        chkn("sw_cnt", 32'(bus.cnt), (k < SW_PULSE - 1) ? k : SW_PULSE - 1);
        chk1("sw_rst1_n_low", bus.rst1_n, 1'b0);
      end else begin
        chkn("sw_exit_state", 32'(bus.state), S_HOLD);
        chkn("sw_exit_cnt", 32'(bus.cnt), 0);
        chk1("sw_pulse_len", k >= SW_PULSE, 1'b1);
        done = 1'b1;
      end
    end
    chk1("sw_rst2_seen", r2_ok, 1'b1);
    chk1("sw_exit_seen", done, 1'b1);
    hold_walk(1'b0, 0);
    wait_ready(1'b0);
  endtask

  // Lock loss and a warm-reset request reach the FSM on the same edge.
  task automatic lock_and_sw();
    int c0;
    bus.lock = 1'b0;
    repeat (SYNC_STAGES) begin
      tick();
      chkn("ls_still_run", 32'(bus.state), S_RUN);
    end
    bus.sw_req = 1'b1;
    tick();
    bus.sw_req = 1'b0;
    chkn("ls_state", 32'(bus.state), S_WAIT);
    chk1("ls_rst1_n", bus.rst1_n, 1'b0);
    chk1("ls_ready", bus.ready, 1'b0);
    chkn("ls_cnt", 32'(bus.cnt), 0);
    c0 = c2_edges;
    for (int k = 0; k < 10; k++) begin
      if ((c2_edges - c0) >= 3) break;
      tick();
    end
    chk1("ls_rst2", bus.rst2, 1'b1);
  endtask

  // Lock drops at a random point in HOLD, then returns; hold restarts from 0.
  task automatic lock_drop_run();
    int d;
    release_to_hold(1'b0);
    d = int'($urandom_range(1, HOLD_CYCLES - 2 - SYNC_STAGES));
    repeat (d) tick();
    chkn("ld_cnt_before", 32'(bus.cnt), d);
    bus.lock = 1'b0;
    for (int s = 1; s <= SYNC_STAGES; s++) begin
      tick();
      chkn("ld_sync_state", 32'(bus.state), S_HOLD);
      chkn("ld_sync_cnt", 32'(bus.cnt), d + s);
    end
    tick();
    chkn("ld_state", 32'(bus.state), S_WAIT);
    chkn("ld_cnt", 32'(bus.cnt), 0);
    chk1("ld_rst1_n", bus.rst1_n, 1'b0);
    bus.lock = 1'b1;
    for (int s = 1; s <= SYNC_STAGES; s++) begin
      tick();
      chkn("ld_wait_state", 32'(bus.state), S_WAIT);
      chk1("ld_wait_rst1_n", bus.rst1_n, 1'b0);
    end
    tick();
    chkn("ld_rehold_state", 32'(bus.state), S_HOLD);
    chkn("ld_rehold_cnt", 32'(bus.cnt), 0);
    hold_walk(1'b0, 0);
    wait_ready(1'b0);
  endtask

  initial begin
    bus.lock   = 1'b1;
    bus.sw_req = 1'b0;
    reset      = 1'b1;
    #1 reset = 1'b0;
    #(3*P1);
    chk_reset_state("por");

    power_up(1'b0);

    sw_test();

    reset = 1'b0;
    #(2*P1);
    chk_reset_state("rst_b");
    power_up(1'b1);

    lock_and_sw();

    reset = 1'b0;
    bus.lock = 1'b1;
    #(2*P1);
    lock_drop_run();

    reset = 1'b0;
    clk2_en = 1'b0;
    #(2*P1);
    release_to_hold(1'b0);
    hold_walk(1'b0, 0);
    repeat (3) begin
      tick();
      chkn("rel2_stuck", 32'(bus.state), S_REL2);
    end
    #2 reset = 1'b0;
    #1;
    chk_reset_state("mid_rel2");
    clk2_en = 1'b1;
    #(2*P1);
    power_up(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
